ipf_array: RTL and testbench
============================

IPF_ARRAY -- requirements
Module: ipf_array

Interface
REQ-001 Parameter DATA_W, default 8, signed pixel/weight width in bits.
REQ-002 Parameter LANES, default 8, pixels per row beat, which is also the number of output lanes; legal range 4..32.
REQ-003 Localparam ACC_W = 2*DATA_W+4, signed per-lane result width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-005 clk  in  1  clock, rising-edge active.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle frame-start command, sampled in IDLE only.
REQ-008 pad_mode  in  1  edge handling, 0 = circular wrap, 1 = zero pad; sampled at start.
REQ-009 w_data  in  9*DATA_W  3x3 kernel; tap k=3*r+c occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
REQ-010 w_valid / w_ready  in / out  1 / 1  kernel-load handshake.
REQ-011 i_data  in  LANES*DATA_W  one image row; pixel j occupies bits [DATA_W*j+DATA_W-1 : DATA_W*j].
REQ-012 i_valid / i_ready / i_last  in / out / in  1 / 1 / 1  row handshake; i_last marks the final row of a frame.
REQ-013 res  out  LANES*ACC_W  lane j occupies bits [ACC_W*j+ACC_W-1 : ACC_W*j].
REQ-014 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 finish  out  1  one-cycle pulse at frame completion.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE->RUN on start; RUN->DONE on the accepted row with i_last=1; DONE->IDLE after exactly one cycle, during which finish=1.
REQ-019 In IDLE: w_ready=1. A transfer (w_valid & w_ready) latches w_data into the kernel register. The kernel register holds its value across frames.
REQ-020 When w_valid and start are both high in the same IDLE cycle, the SHALL latch the kernel and enter RUN; the new kernel applies to that frame.
REQ-021 On entry to RUN, the SHALL clear the three row registers R0 (oldest), R1 and R2 (newest), clear row count, and latch pad_mode.
REQ-022 i_ready = (state==RUN) & !pend & (!res_valid | res_ready). The SHALL assert w_ready=0 outside IDLE.
REQ-023 On a row transfer, the SHALL shift R0<=R1, R1<=R2, R2<=i_data and increment the row count, saturating at 3.
REQ-024 A row transfer that brings the row count to 3 (the 3rd or any later row) SHALL set pend.
REQ-025 On the cycle after pend is set, the SHALL register res, set res_valid=1 and clear pend. Latency is 2 clk edges from the row handshake to res_valid.
REQ-026 Lane j result = sum over r,c in 0..2 of w[3r+c] * Rr[col(j+c-1)], with products signed and the sum in ACC_W with no overflow possible.
REQ-027 Column index out of range (-1 or LANES): pad_mode=0 wraps modulo LANES; pad_mode=1 uses the value 0.
REQ-028 res_valid SHALL hold, and res SHALL remain stable, until res_ready=1. The result clears on handshake unless a new result is registered in the same cycle.
REQ-029 Frames of 1 or 2 rows produce no results; finish still pulses.
REQ-030 A pending or unaccepted result at i_last SHALL be delivered. Entry to DONE waits until pend=0 and res_valid=0 (RUN holds with i_ready=0).
REQ-031 start while busy, and w_valid outside IDLE, SHALL be ignored.

Reset
REQ-032 On rst=1 at a clk edge: state=IDLE, res_valid=0, res=0, pend=0, finish=0, row registers=0, row count=0, kernel register=0, latched pad_mode=0.
REQ-033 rst SHALL override every other input, including mid-frame; a result not yet accepted is discarded.
REQ-034 Outputs SHALL be valid on the first edge after reset: busy=0, w_ready=1, i_ready=0.

Configuration
REQ-035 Macro IPF_ARRAY_RELU_EN defined: each lane result < 0 is replaced by 0 before registering into res.
REQ-036 Macro IPF_ARRAY_RELU_EN undefined: signed results pass unmodified; no other behaviour differs.

Verification
REQ-037 Kernel: centre tap=1, others 0. Rows 1,2,3 with pixel j=j -> one result, lane j = j (row R1), res_valid on the 2nd edge after row 3.
REQ-038 Kernel: all taps=1; rows all pixels=2; LANES=8. pad_mode=0 -> every lane=18. pad_mode=1 -> lanes 0 and 7=12, others=18.
REQ-039 Kernel: all taps=-128; pixels all -128 (DATA_W=8) -> each lane=147456, no overflow.
REQ-040 Hold res_ready=0 for 5 cycles after the first result -> i_ready=0, res unchanged; release -> next row accepted, and a 5-row frame yields exactly 3 results.
REQ-041 2-row frame with i_last on row 2 -> zero res_valid pulses, finish pulses once, busy drops the next cycle.
REQ-042 Assert rst while res_valid=1 mid-frame -> next cycle res_valid=0, busy=0; IPF_ARRAY_RELU_EN build with kernel all -1, pixels 1 -> lanes=0.

Source files
------------

// File: rtl/ipf_array.sv
// ipf_array -- streaming 3x3 convolution over a three-row window.
//
// Rows of LANES signed pixels arrive one per handshake. The three most
// recent rows are kept in R0 (oldest), R1 and R2 (newest). Starting with
// the third row of a frame, every accepted row produces one result beat.
// Each beat holds LANES signed sums of a 3x3 kernel applied around the
// column of each lane, with R1 as the centre row.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, pad_mode       frame start (IDLE only); edge mode, latched at start
//                         (0 = circular wrap, 1 = zero pad)
//   w_data/w_valid/w_ready   3x3 kernel load, accepted in IDLE only
//   i_data/i_valid/i_ready/i_last   row stream; i_last tags the final row
//   res/res_valid/res_ready  per-lane results, ACC_W bits per lane
//   busy                  high whenever the FSM is not in IDLE
//   finish                one-cycle pulse while the FSM is in DONE
//
// Build option
//   IPF_ARRAY_RELU_EN     when defined, negative lane sums are registered as 0.
//
// Timing
//   A row handshake on edge N sets pend. Edge N+1 registers the result and
//   raises res_valid. i_ready stays low while a result is pending or while a
//   result is stalled, so the row window cannot move under a result that has
//   not been computed yet.

module ipf_array #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          pad_mode,
  input  logic [9*DATA_W-1:0]           w_data,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [LANES*DATA_W-1:0]       i_data,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic                          i_last,
  output logic [LANES*(2*DATA_W+4)-1:0] res,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy,
  output logic                          finish
);

  localparam int ACC_W = 2*DATA_W + 4;
  localparam int EXT   = ACC_W - 2*DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef logic [LANES-1:0][DATA_W-1:0] row_t;
  typedef logic [LANES-1:0][ACC_W-1:0]  res_t;

  logic [1:0]              state_q, state_d;
  logic [8:0][DATA_W-1:0]  kern_q,  kern_d;
  row_t                    r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic [1:0]              cnt_q,  cnt_d;
  logic                    pad_q,  pad_d;
  logic                    pend_q, pend_d;
  logic                    last_q, last_d;
  logic                    rv_q,   rv_d;
  res_t                    res_q,  res_d;
  res_t                    lane_res;

  logic w_xfer, i_xfer, r_xfer;

  // ------------------------------------------------------------------
  // Handshakes and status
  // ------------------------------------------------------------------
  assign w_ready = (state_q == S_IDLE);
  // last_q holds the row stream shut once the final row has been taken,
  // while the pending or stalled tail result drains.
  assign i_ready = (state_q == S_RUN) & ~pend_q & ~last_q & (~rv_q | res_ready);
  assign busy    = (state_q != S_IDLE);
  assign finish  = (state_q == S_DONE);

  assign w_xfer = w_valid & w_ready;
  assign i_xfer = i_valid & i_ready;
  assign r_xfer = rv_q & res_ready;

  assign res       = res_q;
  assign res_valid = rv_q;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    kern_d  = kern_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    pend_d  = pend_q;
    last_d  = last_q;
    rv_d    = rv_q;
    res_d   = res_q;

    case (state_q)
      S_IDLE: begin
        // A kernel offered together with start is used for that frame.
        if (w_xfer) kern_d = w_data;
        if (start) begin
          state_d = S_RUN;
          r0_d    = '0;
          r1_d    = '0;
          r2_d    = '0;
          cnt_d   = 2'd0;
          pad_d   = pad_mode;
          pend_d  = 1'b0;
          last_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (i_xfer) begin
          r0_d = r1_q;
          r1_d = r2_q;
          r2_d = i_data;
          if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
          // Row count reaches 3 on this transfer: a full window exists.
          if (cnt_q >= 2'd2) pend_d = 1'b1;
          if (i_last) begin
            // Short frames have nothing to drain and finish at once.
            if (cnt_q >= 2'd2) last_d  = 1'b1;
            else               state_d = S_DONE;
          end
        end else if (last_q && !pend_q && (!rv_q || res_ready)) begin
          // The tail result is being taken (or is already gone).
          state_d = S_DONE;
          last_d  = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result register. pend and a live result never coexist because a row
    // is only accepted when the current result is absent or leaving.
    if (pend_q) begin
      res_d  = lane_res;
      rv_d   = 1'b1;
      pend_d = 1'b0;
    end else if (r_xfer) begin
      res_d = '0;
      rv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kern_q  <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      cnt_q   <= 2'd0;
      pad_q   <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      rv_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      kern_q  <= kern_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      rv_q    <= rv_d;
      res_q   <= res_d;
    end
  end

  // ------------------------------------------------------------------
  // Per-lane 3x3 multiply-accumulate
  // ------------------------------------------------------------------
  row_t rows [3];
  assign rows[0] = r0_q;
  assign rows[1] = r1_q;
  assign rows[2] = r2_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    // Neighbour columns are fixed per lane. Only the two edge lanes ever
    // reach outside the row, and then either wrap or read zero.
    localparam int CL = (j == 0)       ? LANES-1 : j-1;
    localparam int CR = (j == LANES-1) ? 0       : j+1;
    localparam bit EL = (j == 0);
    localparam bit ER = (j == LANES-1);

    logic [DATA_W-1:0]       px [9];
    logic signed [ACC_W-1:0] pe [9];
    logic signed [ACC_W-1:0] sum;

    for (genvar r = 0; r < 3; r++) begin : g_row
      assign px[3*r]   = (EL && pad_q) ? '0 : rows[r][CL];
      assign px[3*r+1] = rows[r][j];
      assign px[3*r+2] = (ER && pad_q) ? '0 : rows[r][CR];
    end

    for (genvar k = 0; k < 9; k++) begin : g_tap
      logic signed [2*DATA_W-1:0] prod;
      // Both operands are sign-extended to product width. The low 2*DATA_W
      // bits then hold the exact signed product.
      assign prod  = $signed({{DATA_W{kern_q[k][DATA_W-1]}}, kern_q[k]}) *
                     $signed({{DATA_W{px[k][DATA_W-1]}},     px[k]});
      assign pe[k] = {{EXT{prod[2*DATA_W-1]}}, prod};
    end

    // Nine products of at most 2^(2*DATA_W-2) each fit well inside ACC_W.
    assign sum = pe[0] + pe[1] + pe[2] + pe[3] + pe[4] +
                 pe[5] + pe[6] + pe[7] + pe[8];

`ifdef IPF_ARRAY_RELU_EN
    assign lane_res[j] = sum[ACC_W-1] ? '0 : sum;
`else
    assign lane_res[j] = sum;
`endif
  end

endmodule

// File: tb/tb_ipf_array.sv
module tb_ipf_array;
  localparam int DW = 8;
  localparam int L  = 8;
  localparam int AW = 2*DW + 4;

  logic              clk = 1'b0;
  logic              rst, start, pad_mode;
  logic [9*DW-1:0]   w_data;
  logic              w_valid, w_ready;
  logic [L*DW-1:0]   i_data;
  logic              i_valid, i_ready, i_last;
  logic [L*AW-1:0]   res;
  logic              res_valid, res_ready;
  logic              busy, finish;

  ipf_array #(.DATA_W(DW), .LANES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .pad_mode(pad_mode),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready), .i_last(i_last),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef int row_a [L];
  int              kern_m [9];
  row_a            frm [$];
  bit              pad_m;
  logic [L*AW-1:0] got [$];
  logic [L*AW-1:0] expq [$];
  int              rv_cnt = 0;
  int              fin_cnt = 0;
  bit              rr_rand = 1'b0;
  bit              rr_fix  = 1'b1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [L*AW-1:0] act, input logic [L*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pixel at a possibly out-of-range column, following the frame's edge rule.
  function automatic int pix(input row_a row, input int col, input bit pad);
    if (col < 0 || col >= L) return pad ? 0 : row[(col + L) % L];
    return row[col];
  endfunction

  function automatic logic [L*AW-1:0] model(input row_a ra, input row_a rb, input row_a rc, input bit pad);
    logic [L*AW-1:0] v;
    int s;
    v = '0;
    for (int j = 0; j < L; j++) begin
      s = 0;
      for (int c = 0; c < 3; c++)
        s += kern_m[c]   * pix(ra, j+c-1, pad)
           + kern_m[3+c] * pix(rb, j+c-1, pad)
           + kern_m[6+c] * pix(rc, j+c-1, pad);
`ifdef IPF_ARRAY_RELU_EN
      if (s < 0) s = 0;
`endif
      v[j*AW +: AW] = s[AW-1:0];
    end
    return v;
  endfunction

  function automatic longint lane(input logic [L*AW-1:0] v, input int j);
    logic signed [AW-1:0] x;
    x = v[j*AW +: AW];
    return longint'(x);
  endfunction

  // ---------------- monitors / res_ready driver ----------------
  logic            st_pend = 1'b0;
  logic [L*AW-1:0] st_val;
  always @(posedge clk) begin
    if (rst) begin
      st_pend = 1'b0;
    end else begin
      if (res_valid && res_ready) got.push_back(res);
      if (res_valid) rv_cnt++;
      if (finish) fin_cnt++;
      if (st_pend) begin
        chk("stall_valid_held", res_valid, 1);
        chkv("stall_res_stable", res, st_val);
      end
      st_pend = res_valid && !res_ready;
      st_val  = res;
    end
  end

  always @(posedge clk) begin
    #2;
    res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fix;
  end

  // ---------------- stimulus tasks ----------------
  function automatic logic [9*DW-1:0] kpack();
    logic [9*DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = kern_m[k][DW-1:0];
    return w;
  endfunction

  task automatic send_row(input row_a row, input bit last, input bit lat);
    int n;
    i_valid = 1'b1;
    i_last  = last;
    for (int j = 0; j < L; j++) i_data[j*DW +: DW] = row[j][DW-1:0];
    n = 0;
    while (!i_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("i_ready_timeout", 0, 1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (lat) begin
      chk("lat_edge1_no_valid", res_valid, 0);
      @(negedge clk);
      chk("lat_edge2_valid", res_valid, 1);
    end
  endtask

  task automatic start_frame(input int lmode);
    if (lmode == 1) begin
      w_valid = 1'b1; w_data = kpack();
      @(negedge clk);
      w_valid = 1'b0;
    end
    start = 1'b1; pad_mode = pad_m;
    w_valid = (lmode == 2); w_data = kpack();
    @(negedge clk);
    start = 1'b0; w_valid = 1'b0;
    pad_mode = ~pad_m;  // must have been latched already
    chk("busy_in_run", busy, 1);
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!finish && n < 500) begin @(negedge clk); n++; end
    chk("finish_seen", finish, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  // lmode: 0 = keep kernel, 1 = load then start, 2 = load with start.
  task automatic run_frame(input int lmode, input bit junk, input int hold);
    int f0;
    logic [L*AW-1:0] sv;
    got.delete();
    expq.delete();
    for (int n = 2; n < frm.size(); n++) expq.push_back(model(frm[n-2], frm[n-1], frm[n], pad_m));
    f0 = fin_cnt;
    start_frame(lmode);
    if (junk) begin
      w_valid = 1'b1; start = 1'b1;
      w_data = 72'({$urandom(), $urandom(), $urandom()});
    end
    for (int n = 0; n < frm.size(); n++) begin
      if (n == frm.size() - 1) begin w_valid = 1'b0; start = 1'b0; end
      send_row(frm[n], n == frm.size() - 1, n >= 2);
      if (n == 2 && hold > 0) begin
        sv = res;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          chk("hold_i_ready_low", i_ready, 0);
          chkv("hold_res_same", res, sv);
        end
        rr_fix = 1'b1;
      end
    end
    w_valid = 1'b0; start = 1'b0;
    wait_finish();
    chk("result_count", got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) chkv("result_value", got[i], expq[i]);
    chk("finish_once", fin_cnt - f0, 1);
  endtask

  function automatic row_a rand_row();
    row_a r;
    for (int j = 0; j < L; j++) r[j] = int'($urandom_range(0, 255)) - 128;
    return r;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit centre; int kv; bit ramp; int pv; bit pad; int e_edge; int e_mid;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #800000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    row_a r;
    int rv0;
    logic [L*AW-1:0] sv0;

    tbl[0] = '{1'b1,    0, 1'b1,    0, 1'b0,     0,      0};
    tbl[1] = '{1'b1,    0, 1'b1,    0, 1'b1,     0,      0};
    tbl[2] = '{1'b0,    1, 1'b0,    2, 1'b0,    18,     18};
    tbl[3] = '{1'b0,    1, 1'b0,    2, 1'b1,    12,     18};
    tbl[4] = '{1'b0, -128, 1'b0, -128, 1'b0, 147456, 147456};
    tbl[5] = '{1'b0, -128, 1'b0, -128, 1'b1,  98304, 147456};

    rst = 1'b1; start = 1'b0; pad_mode = 1'b0; w_data = '0; w_valid = 1'b0;
    i_data = '0; i_valid = 1'b0; i_last = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_finish", finish, 0);
    chkv("rst_res", res, '0);
    rst = 1'b0;
    @(negedge clk);

    // Table of single-result frames with hand-computed lane values.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 9; k++) kern_m[k] = tbl[t].centre ? ((k == 4) ? 1 : 0) : tbl[t].kv;
      for (int j = 0; j < L; j++) r[j] = tbl[t].ramp ? j : tbl[t].pv;
      frm.delete();
      repeat (3) frm.push_back(r);
      pad_m = tbl[t].pad;
      run_frame((t % 2 == 0) ? 2 : 1, 1'b0, 0);
      chk("tbl_got_one", got.size(), 1);
      if (got.size() > 0)
        for (int j = 0; j < L; j++)
          chk("tbl_lane", lane(got[0], j),
              tbl[t].ramp ? j : ((j == 0 || j == L-1) ? tbl[t].e_edge : tbl[t].e_mid));
    end

    // Back-pressure: result held 5 cycles, 5-row frame gives 3 results.
    for (int k = 0; k < 9; k++) kern_m[k] = int'($urandom_range(0, 255)) - 128;
    frm.delete();
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < L; j++) r[j] = ((n * 8 + j) % 100) - 50;
      frm.push_back(r);
    end
    pad_m = 1'b0;
    rr_fix = 1'b0;
    run_frame(2, 1'b0, 5);
    chk("stall_frame_results", got.size(), 3);

    // Two-row frame: no results, one finish pulse.
    rv0 = rv_cnt;
    frm.delete();
    frm.push_back(rand_row());
    frm.push_back(rand_row());
    run_frame(0, 1'b0, 0);
    chk("short_no_res_valid", rv_cnt - rv0, 0);

    // Reset while a result is waiting.
    rr_fix = 1'b0;
    for (int k = 0; k < 9; k++) kern_m[k] = int'($urandom_range(0, 255)) - 128;
    pad_m = 1'b1;
    start_frame(1);
    send_row(rand_row(), 1'b0, 1'b0);
    send_row(rand_row(), 1'b0, 1'b0);
    send_row(rand_row(), 1'b0, 1'b1);
    sv0 = res;
    chk("pre_rst_valid", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_w_ready", w_ready, 1);
    chk("mid_rst_i_ready", i_ready, 0);
    chkv("mid_rst_res", res, '0);
    rst = 1'b0;
    rr_fix = 1'b1;
    @(negedge clk);

    // Kernel register was cleared by reset: a frame without a load is all zero.
    for (int k = 0; k < 9; k++) kern_m[k] = 0;
    frm.delete();
    repeat (3) frm.push_back(rand_row());
    pad_m = 1'b0;
    run_frame(0, 1'b0, 0);
    if (got.size() > 0) chkv("zero_kernel_after_rst", got[0], '0);

    // Negative sums: passed through, or clamped in the ReLU build.
    for (int k = 0; k < 9; k++) kern_m[k] = -1;
    for (int j = 0; j < L; j++) r[j] = 1;
    frm.delete();
    repeat (3) frm.push_back(r);
    pad_m = 1'b0;
    run_frame(2, 1'b0, 0);
`ifdef IPF_ARRAY_RELU_EN
    if (got.size() > 0) chk("relu_lane0", lane(got[0], 0), 0);
`else
    if (got.size() > 0) chk("neg_lane0", lane(got[0], 0), -9);
`endif

    // Randomised frames with random back-pressure and ignored junk inputs.
    rr_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < 9; k++) kern_m[k] = int'($urandom_range(0, 255)) - 128;
      frm.delete();
      for (int n = 0; n < int'($urandom_range(1, 6)); n++) frm.push_back(rand_row());
      pad_m = 1'($urandom_range(0, 1));
      run_frame(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 0);
    end
    rr_rand = 1'b0;
    rr_fix = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
